reg_dump_streamer: RTL and testbench
====================================

Name: reg_dump_streamer

Overview:
Debug reader on the register-file side of the pipelined CPU. It consumes the flattened 32x32 register snapshot bus and streams the registers out one word per handshake, as (index, data) pairs, to a display or serial debug sink. On request it captures a coherent snapshot, then drives words 0..NREGS-1 under valid/ready flow control. It is the read-out counterpart of the register file's write path.

Parameters:
NREGS, 32, number of registers in the snapshot; word i occupies bits [i*DW +: DW]
DW, 32, register width in bits
IW, 5, index width; must satisfy 2**IW >= NREGS

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
start  in  1  dump request; sampled only in IDLE
abort  in  1  synchronous abort of an active dump
regs_flat  in  NREGS*DW  flattened register snapshot; word 0 in LSBs
out_valid  out  1  out_data/out_idx hold a word
out_ready  in  1  sink accepts the word when out_valid&out_ready
out_data  out  DW  register value
out_idx  out  IW  register index of out_data
out_last  out  1  high with the word at index NREGS-1
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse after the last word transfers

Behaviour:
- Reset (async, rst=1): state=IDLE, idx=0, snapshot cleared. out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0. Reset mid-stream kills the dump immediately and emits no done.
- States: IDLE, STREAM, DONE.
- IDLE: if start=1 at posedge: latch regs_flat into the snapshot register, set idx=0, go to STREAM. Otherwise hold.
- Snapshot: taken at posedge. The register file writes on negedge, so the snapshot is coherent. Later register writes do not affect an in-progress dump.
- Word 0 is always emitted as 0, regardless of regs_flat[DW-1:0], to match r0 semantics.
- STREAM: out_valid=1, out_data=snapshot word idx, out_idx=idx, out_last=(idx==NREGS-1).
  - On transfer (valid&ready): if idx==NREGS-1, go to DONE; else idx=idx+1.
  - With no transfer, all outputs stay stable. out_valid never drops without a transfer, except on abort or reset.
- DONE: done=1 for exactly one cycle, out_valid=0, then IDLE. start is ignored in DONE.
- Latency: start sampled at edge k gives out_valid=1 from edge k. First word is idx 0. With out_ready tied high, NREGS transfers take NREGS consecutive cycles, and done is high in the cycle after the last transfer.
- abort=1 in STREAM: go to IDLE at the next posedge. No transfer is counted that cycle even if out_ready=1, and no done pulse is emitted. abort in IDLE or DONE is ignored; the DONE to IDLE transition proceeds normally.
- abort has priority over a simultaneous transfer.
- start while busy=1 is ignored. It is not queued.
- start and abort high together in IDLE: start wins; abort is ignored because it only acts in STREAM.
- idx never wraps. The STREAM exit occurs at NREGS-1, so no index >= NREGS is ever presented.
- Outputs are registered or decoded directly from state/idx/snapshot. There is no combinational path from out_ready to out_valid.

Decomposition:
- Shared CPU debug package: state encoding constants (IDLE=2'd0, STREAM=2'd1, DONE=2'd2) and the NREGS/DW defaults shared with the register file.
- One natural sub-module: reg_snapshot_mux. It holds the NREGS*DW snapshot register, with load enable, and the indexed word select with the r0-zero rule. The FSM, counter and handshake stay in the top module.

Test Plan:
- regs_flat word i = 32'hA000_0000+i (word 0 = 32'hDEAD_BEEF), start pulse, out_ready=1 → 32 words in 32 consecutive cycles. out_idx runs 0..31, out_data=0 for idx 0 and A000_0000+i otherwise. out_last only with idx 31. done pulses one cycle later. busy is high from start through DONE.
- Same stimulus with out_ready toggled 1,0,0,1 repeating → each word is held stable while ready=0. Exactly 32 transfers occur, with no duplicates or skips. done follows the last transfer.
- Start, then change regs_flat to all 32'hFFFF_FFFF after the first transfer → all streamed words still carry the captured values.
- Abort asserted with out_ready=1 while idx=10 → no transfer at idx 10. Next cycle: IDLE, out_valid=0, busy=0, done is never pulsed. A new start then begins again at idx 0.
- Second start during STREAM and during DONE → ignored. The stream completes unchanged and exactly one done pulse occurs.
- rst asserted asynchronously mid-cycle at idx 5 → outputs clear immediately, without waiting for a clock edge. After rst is released: IDLE with idx 0, and no done pulse.

Source files
------------

// File: rtl/reg_dump_streamer_pkg.sv
// Shared CPU debug definitions: streamer state encoding and register-file
// geometry defaults used by both the register file and its debug readers.
package reg_dump_streamer_pkg;

  localparam int NREGS_DEFAULT = 32;
  localparam int DW_DEFAULT    = 32;
  localparam int IW_DEFAULT    = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } dump_state_t;

endpackage

// File: rtl/reg_dump_streamer_snapshot_mux.sv
// Snapshot register for the flattened register file plus indexed word select.
// Word 0 always reads as zero to mirror r0 semantics.
module reg_snapshot_mux
  import reg_dump_streamer_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int DW    = DW_DEFAULT,
  parameter int IW    = IW_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [NREGS*DW-1:0] i_regs_flat,
  input  logic [IW-1:0]       i_idx,
  output logic [DW-1:0]       o_word
);

  logic [DW-1:0] r_snap [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_snap[i] <= '0;
      end
    end else if (i_load) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_snap[i] <= i_regs_flat[i*DW +: DW];
      end
    end
  end

  // Loop starts at 1 so index 0 falls through to the zero default.
  always_comb begin
    o_word = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      if (i_idx == IW'(i)) begin
        o_word = r_snap[i];
      end
    end
  end

endmodule

// File: rtl/reg_dump_streamer.sv
// Debug reader: captures a register-file snapshot on request and streams it
// out as (index, data) words under valid/ready flow control.
module reg_dump_streamer
  import reg_dump_streamer_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int DW    = DW_DEFAULT,
  parameter int IW    = IW_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [NREGS*DW-1:0] regs_flat,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic [IW-1:0]       out_idx,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NREGS - 1);

  dump_state_t   r_state;
  dump_state_t   w_state_nxt;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idx_nxt;
  logic          w_load;
  logic [DW-1:0] w_word;

  reg_snapshot_mux #(
    .NREGS (NREGS),
    .DW    (DW),
    .IW    (IW)
  ) u_snap (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_regs_flat (regs_flat),
    .i_idx       (r_idx),
    .o_word      (w_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Outputs decode from state/idx only; out_ready steers next state, never out_valid.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_load      = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        out_valid = 1'b1;
        out_last  = (r_idx == LAST_IDX);
        // abort outranks a transfer in the same cycle
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (out_ready) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    out_data = out_valid ? w_word : '0;
  end

  assign out_idx = r_idx;

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Self-checking bench for reg_dump_streamer against a transaction-level model.
module tb_reg_dump_streamer;

  localparam int NREGS = 32;
  localparam int DW    = 32;
  localparam int IW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                abort;
  logic [NREGS*DW-1:0] regs_flat;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       out_data;
  logic [IW-1:0]       out_idx;
  logic                out_last;
  logic                busy;
  logic                done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_dump_streamer #(
    .NREGS (NREGS),
    .DW    (DW),
    .IW    (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .regs_flat (regs_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  // Reference model: the register file contents, the captured snapshot,
  // whether a dump is active, the next word owed and whether done is due.
  logic [DW-1:0] regs [NREGS];
  logic [DW-1:0] snap [NREGS];
  bit m_active;
  bit m_done_due;
  int m_next;
  int obs_xfers;
  int obs_dones;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_regs();
    for (int i = 0; i < NREGS; i++) regs_flat[i*DW +: DW] = regs[i];
  endtask

  task automatic check_outputs();
    check("valid", 32'(out_valid), 32'(m_active));
    check("busy", 32'(busy), 32'(m_active || m_done_due));
    check("done", 32'(done), 32'(m_done_due));
    if (m_active) begin
      check("idx", 32'(out_idx), 32'(m_next));
      check("data", out_data, snap[m_next]);
      check("last", 32'(out_last), 32'(m_next == NREGS - 1));
    end else begin
      check("last_idle", 32'(out_last), 32'd0);
    end
  endtask

  // Check current outputs, advance the model by one clock, then step the DUT.
  task automatic tick();
    check_outputs();
    if (done === 1'b1) obs_dones++;
    if (out_valid === 1'b1 && out_ready && !abort) obs_xfers++;
    if (m_done_due) begin
      m_done_due = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1;
        m_next   = 0;
        for (int i = 0; i < NREGS; i++) snap[i] = (i == 0) ? '0 : regs[i];
      end
    end else if (abort) begin
      m_active = 0;
    end else if (out_ready) begin
      if (m_next == NREGS - 1) begin
        m_active   = 0;
        m_done_due = 1;
      end else begin
        m_next++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    m_active   = 0;
    m_done_due = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_idx", 32'(out_idx), 32'd0);
    check("post_rst_valid", 32'(out_valid), 32'd0);
  endtask

  // mode: 0 ready high, 1 ready 1,0,0,1 pattern, 2 random ready.
  task automatic run(input string name, input int mode, input bit mutate, input bit restart,
                     input int abort_idx, input int rst_idx, input bit start_abort);
    int  x0, d0, exp_x, exp_d, c;
    bit  mutated;
    x0 = obs_xfers;
    d0 = obs_dones;
    mutated = 0;
    exp_x = (abort_idx >= 0) ? abort_idx : (rst_idx >= 0) ? rst_idx : NREGS;
    exp_d = (abort_idx >= 0 || rst_idx >= 0) ? 0 : 1;
    start = 1'b1;
    abort = start_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (c = 0; c < 400 && (m_active || m_done_due); c++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((c % 4) == 0) || ((c % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (mutate && !mutated && (obs_xfers - x0) == 1) begin
        for (int i = 0; i < NREGS; i++) regs[i] = '1;
        apply_regs();
        mutated = 1;
      end
      start = restart && (c == 3 || m_done_due);
      if (m_active && m_next == abort_idx) begin
        abort     = 1'b1;
        out_ready = 1'b1;
      end
      if (m_active && m_next == rst_idx) begin
        async_reset();
        break;
      end
      tick();
      abort = 1'b0;
    end
    start     = 1'b0;
    out_ready = 1'b0;
    check({name, "_finished"}, 32'(m_active || m_done_due), 32'd0);
    for (int k = 0; k < 3; k++) tick();
    check({name, "_xfers"}, 32'(obs_xfers - x0), 32'(exp_x));
    check({name, "_dones"}, 32'(obs_dones - d0), 32'(exp_d));
  endtask

  task automatic load_pattern();
    for (int i = 0; i < NREGS; i++) regs[i] = 32'hA000_0000 + 32'(i);
    regs[0] = 32'hDEAD_BEEF;
    apply_regs();
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    m_active   = 0;
    m_done_due = 0;
    m_next     = 0;
    obs_xfers  = 0;
    obs_dones  = 0;
    for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
    apply_regs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_data", out_data, 32'd0);
    check("reset_idx", 32'(out_idx), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    load_pattern();
    run("full", 0, 0, 0, -1, -1, 0);
    run("stall", 1, 0, 0, -1, -1, 0);
    run("coherent", 0, 1, 0, -1, -1, 0);
    load_pattern();
    run("abort", 0, 0, 0, 10, -1, 0);
    run("after_abort", 0, 0, 0, -1, -1, 0);
    run("restart_ignored", 0, 0, 1, -1, -1, 0);
    run("async_rst", 0, 0, 0, -1, 5, 0);
    run("after_rst", 1, 0, 0, -1, -1, 0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
      apply_regs();
      run("random", 2, 0, 0, -1, -1, (r == 0));
    end

    abort = 1'b1;
    tick();
    tick();
    abort = 1'b0;
    check("abort_idle_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
